// File: rtl/apb_master_bridge_pkg.sv
// Shared APB definitions: FSM state encodings and default bus widths.
// The GPIO APB slave imports the same package so both sides agree on encodings.
package apb_defs;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2,
    APB_RESP   = 2'd3
  } apb_state_e;

  // Counter width for a wait limit; a zero limit still needs one bit of storage.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response port plus APB initiator signals of the bridge.
// 'master' is the bridge's view, 'slave' is the requester plus APB target view.
interface apb_master_bridge_if import apb_defs::*; #(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_timeout.sv
// ACCESS-phase wait counter: cleared in SETUP, counts pready-low cycles, saturates.
// o_expired flags the cycle whose count would reach LIMIT; LIMIT=0 never expires.
module apb_timeout_counter import apb_defs::*; #(
  parameter int LIMIT = 16
) (
  input  logic pclk,
  input  logic presetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int              CNT_W = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'((LIMIT > 0) ? LIMIT - 1 : 0);

  logic [CNT_W-1:0] r_count;

  // NOTE: reset is synchronous, so presetn is sampled as an ordinary input here.
  always_ff @(posedge pclk) begin
    if (!presetn || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (LIMIT != 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: valid/ready command in, SETUP/ACCESS transfer out, one-cycle response.
// Every bus output is registered; only cmd_ready is decoded from the state.
module apb_master_bridge import apb_defs::*; #(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_bridge_if.master  bus
);

  apb_state_e        r_state;
  apb_state_e        w_state_nxt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic              w_pwrite_nxt;
  logic [ADDR_W-1:0] r_paddr;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic              w_rsp_err_nxt;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_expired;

  apb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .pclk      (pclk),
    .presetn   (presetn),
    .i_clear   (r_state == APB_SETUP),
    .i_enable  ((r_state == APB_ACCESS) && !bus.pready),
    .o_expired (w_expired)
  );

  // NOTE: every next-value is defaulted to its hold value first so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_pwrite_nxt    = r_pwrite;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    case (r_state)
      APB_IDLE: begin
        if (bus.cmd_valid) begin
          w_paddr_nxt  = bus.cmd_addr;
          w_pwdata_nxt = bus.cmd_wdata;
          w_pwrite_nxt = bus.cmd_write;
          w_state_nxt  = APB_SETUP;
        end
      end
      APB_SETUP: w_state_nxt = APB_ACCESS;
      APB_ACCESS: begin
        // A ready slave completes the transfer even in the cycle the limit is hit.
        if (bus.pready) begin
          w_state_nxt     = APB_RESP;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : bus.prdata;
        end else if (w_expired) begin
          w_state_nxt     = APB_RESP;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
        end
      end
      APB_RESP: w_state_nxt = APB_IDLE;
      default:  w_state_nxt = APB_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_state     <= APB_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_psel      <= (w_state_nxt == APB_SETUP) || (w_state_nxt == APB_ACCESS);
      r_penable   <= (w_state_nxt == APB_ACCESS);
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= (w_state_nxt == APB_RESP);
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
    end
  end

  assign bus.cmd_ready = (r_state == APB_IDLE) && presetn;
  assign bus.psel      = r_psel;
  assign bus.penable   = r_penable;
  assign bus.pwrite    = r_pwrite;
  assign bus.paddr     = r_paddr;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: vector table driven through a scoreboard, a small APB
// register-file slave with programmable waits, and a protocol monitor on the falling edge.
module tb_apb_master_bridge;
  import apb_defs::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- APB slave model ----------------
  logic [31:0] mem [16] = '{2: 32'hDEAD_BEEF, 4: 32'h0BAD_F00D, default: 32'h0};
  int sl_waits;
  bit sl_hang;
  int acc_seen = 0;

  always @(negedge pclk) begin
    if (bus.psel && bus.penable) begin
      bus.pready = !sl_hang && (acc_seen == sl_waits);
      bus.prdata = bus.pready ? mem[bus.paddr[5:2]] : (32'hBAD0_0000 | 32'(acc_seen));
      if (bus.pready && bus.pwrite) mem[bus.paddr[5:2]] = bus.pwdata;
      acc_seen++;
    end else begin
      bus.pready = 1'b0;
      bus.prdata = 32'h5A5A_5A5A;
      acc_seen   = 0;
    end
  end

  // ---------------- scoreboard + protocol monitor ----------------
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          rsp_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_psel, prev_setup, prev_rsp;
  logic [31:0] ph_addr, ph_wdata;
  logic ph_write;
  int setups = 0;

  always @(negedge pclk) begin
    if (!presetn) begin
      prev_psel  = 1'b0;
      prev_setup = 1'b0;
      prev_rsp   = 1'b0;
    end else begin
      if (prev_rsp) check("rsp_one_cycle", bus.rsp_valid, 1'b0);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
          check("rsp_err", bus.rsp_err, mon_e.err);
          check("rsp_cycle", cyc, mon_e.rsp_cyc);
          check("rsp_psel_low", {bus.psel, bus.penable}, 2'b00);
        end
      end
      if (bus.psel || bus.rsp_valid) check("cmd_ready_busy", bus.cmd_ready, 1'b0);
      if (prev_setup) check("setup_then_access", {bus.psel, bus.penable}, 2'b11);
      if (bus.psel && !bus.penable) begin
        check("psel_gap", prev_psel, 1'b0);
        setups++;
        ph_addr  = bus.paddr;
        ph_wdata = bus.pwdata;
        ph_write = bus.pwrite;
        if (sb.size() != 0) begin
          check("setup_paddr", bus.paddr, sb[0].addr);
          check("setup_pwrite", bus.pwrite, sb[0].write);
          check("setup_pwdata", bus.pwdata, sb[0].wdata);
        end
      end else if (bus.psel && bus.penable) begin
        check("access_after_psel", prev_psel, 1'b1);
        check("paddr_stable", bus.paddr, ph_addr);
        check("pwdata_stable", bus.pwdata, ph_wdata);
        check("pwrite_stable", bus.pwrite, ph_write);
      end
      prev_psel  = bus.psel;
      prev_setup = bus.psel && !bus.penable;
      prev_rsp   = bus.rsp_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input bit hang, input logic [31:0] exp_rdata,
                      input bit hold);
    exp_t e;
    int   t;
    @(negedge pclk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    t = 0;
    while (!bus.cmd_ready && t < 60) begin
      @(negedge pclk);
      t++;
    end
    if (!bus.cmd_ready) begin
      check("accept_timeout", bus.cmd_ready, 1'b1);
    end else begin
      sl_waits  = waits;
      sl_hang   = hang;
      e.addr    = addr;
      e.write   = wr;
      e.wdata   = wdata;
      e.rdata   = (wr || hang) ? 32'h0 : exp_rdata;
      e.err     = hang;
      e.rsp_cyc = cyc + 3 + (hang ? TMO - 1 : waits);
      sb.push_back(e);
    end
    @(posedge pclk);
    #1;
    if (!hold) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge pclk);
      t++;
    end
    check("drain", sb.size(), 0);
    @(negedge pclk);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          hang;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, t;
    vecs[0] = '{1'b1, 32'h04, 32'hA5A5_0001, 1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h08, 32'h1111_0001, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h04, 32'h1111_0002, 0, 1'b0, 32'hA5A5_0001};
    vecs[3] = '{1'b1, 32'h0C, 32'h1234_5678, TMO - 1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0C, 32'h1111_0004, 0, 1'b0, 32'h1234_5678};
    vecs[5] = '{1'b0, 32'h08, 32'h1111_0005, 0, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h10, 32'hCAFE_F00D, 0, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 32'h10, 32'h1111_0007, 3, 1'b0, 32'h0BAD_F00D};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    sl_waits = 0;
    sl_hang  = 1'b0;

    // reset state
    repeat (3) @(negedge pclk);
    check("rst_psel", bus.psel, 1'b0);
    check("rst_penable", bus.penable, 1'b0);
    check("rst_pwrite", bus.pwrite, 1'b0);
    check("rst_paddr", bus.paddr, 32'h0);
    check("rst_pwdata", bus.pwdata, 32'h0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    presetn = 1'b1;
    #1;
    check("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

    // table-driven transfers
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].hang,
           vecs[i].rdata, 1'b0);
      wait_done();
    end

    // back-to-back with cmd_valid held: write then read back the same register
    s0 = setups;
    send(1'b1, 32'h14, 32'h600D_0001, 0, 1'b0, 32'h0, 1'b1);
    send(1'b0, 32'h14, 32'h0, 1, 1'b0, 32'h600D_0001, 1'b0);
    wait_done();
    check("b2b_setups", setups - s0, 2);

    // reset in the middle of ACCESS drops the transfer silently
    send(1'b0, 32'h08, 32'h0, 0, 1'b1, 32'h0, 1'b0);
    t = 0;
    while (!(bus.psel && bus.penable) && t < 20) begin
      @(negedge pclk);
      t++;
    end
    check("reached_access", {bus.psel, bus.penable}, 2'b11);
    repeat (2) @(negedge pclk);
    presetn = 1'b0;
    @(negedge pclk);
    check("rst_mid_psel", bus.psel, 1'b0);
    check("rst_mid_penable", bus.penable, 1'b0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    sb.delete();
    @(negedge pclk);
    check("rst_mid_rsp_valid2", bus.rsp_valid, 1'b0);
    presetn = 1'b1;
    #1;
    check("rst_mid_cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge pclk);
    check("rst_mid_no_rsp", bus.rsp_valid, 1'b0);

    // recovery: timeout counter starts clean, 7 waits still completes normally
    send(1'b0, 32'h04, 32'h0, TMO - 1, 1'b0, 32'hA5A5_0001, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
